// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared types and helpers for the data-memory responder:
//             FSM state encoding, word size, and address decode functions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int unsigned WORD_BYTES = 4;

    // True when addr lies in [base, base + WORD_BYTES*depth). The 33-bit
    // arithmetic keeps the upper bound from wrapping past 2^32, so an address
    // near the top of the space is never mistaken for an in-range one.
    function automatic logic addr_in_range(
        input logic [31:0]  addr,
        input logic [31:0]  base,
        input int unsigned  depth
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) * 33'(WORD_BYTES));
        return (a >= lo) && (a < hi);
    endfunction

    // Word index of a byte address relative to base; byte offset bits drop out.
    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> $clog2(WORD_BYTES);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : Single-port synchronous RAM of 32-bit words with per-byte write
//             enables and a registered read port. Contents are not reset.
//  Ports    : clk   - rising-edge clock
//             en    - access enable for this cycle
//             we    - 1 = write lanes selected by be, 0 = read
//             be    - byte-lane write enables (lane i = bits [8i+7:8i])
//             idx   - word index
//             wdata - write data, lane aligned
//             rdata - registered read data, updated only on read accesses
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[idx];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for the core data-memory port. Accepts one
//             load/store at a time, waits LATENCY cycles, performs the array
//             access and returns data or an out-of-range error over a
//             valid/ready response channel.
//  Ports    : clk, rst (synchronous, active-low)
//             req_valid/req_ready, req_we, req_addr, req_wdata, req_be
//             resp_valid/resp_ready, resp_rdata, resp_err
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;

    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_load_ok;
    logic               r_err;

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_handshake;
    logic               w_in_range;
    logic               w_arr_en;
    logic               w_arr_we;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_arr_rdata;

    // ------------------------------------------------------------------
    // Next-state logic. The counter holds the number of WAIT cycles still
    // to go after the current one, so WAIT is always visited for exactly
    // LATENCY+1 cycles and the response appears LATENCY+1 edges after
    // acceptance (one edge for LATENCY=0).
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 4'(LATENCY);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_enter_resp = 1'b1;
                    w_state_nxt  = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter and response flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_load_ok <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_enter_resp) begin
                r_load_ok <= !r_we && w_in_range;
                r_err     <= !w_in_range;
            end else if (w_handshake) begin
                r_load_ok <= 1'b0;
                r_err     <= 1'b0;
            end
        end
    end

    // Request capture; the held copy is what the array access uses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    assign w_in_range = addr_in_range(r_addr, BASE_ADDR, DEPTH_WORDS);
    assign w_idx      = c_IDX_W'(word_index(r_addr, BASE_ADDR));

    // Array is touched only on the RESP entry edge, only in range, and never
    // while reset is asserted, so a store dropped in WAIT never commits.
    assign w_arr_en = rst && w_enter_resp && w_in_range;
    assign w_arr_we = r_we;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (w_arr_en),
        .we    (w_arr_we),
        .be    (r_be),
        .idx   (w_idx),
        .wdata (r_wdata),
        .rdata (w_arr_rdata)
    );

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    // The array read register only changes on a read access, so gating it
    // with the load flag yields stable data during RESP and zero elsewhere.
    assign resp_rdata = r_load_ok ? w_arr_rdata : 32'd0;
    assign resp_err   = r_err;

endmodule : dmem_responder
`default_nettype wire
